// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the data-side memory and MMIO block:
// MMIO register offsets, STATUS bit positions and UART state encodings.
package data_mem_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/data_mem_mmio_uart.sv
// UART transmit path: byte FIFO feeding an 8N1 serializer.
// The FSM pops the FIFO head in IDLE; the line output is registered.
module uart_tx_fifo
  import data_mem_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 868,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1,
  localparam int BW = $clog2(BAUD_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          tx
);

  uart_state_e   state_q, state_d;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop, push_ok, baud_last;

  assign full      = cnt_q == CW'(FIFO_DEPTH);
  assign empty     = cnt_q == '0;
  assign count     = cnt_q;
  assign busy      = state_q != UART_IDLE;
  assign tx        = tx_q;
  assign baud_last = baud_q == BW'(BAUD_DIV - 1);
  // A pop in the same cycle frees a slot, so a push at full still fits.
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      UART_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          baud_d  = '0;
          bit_d   = '0;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = UART_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7)
            state_d = UART_STOP;
          else
            bit_d = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = UART_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
    // Line level follows the state being entered, so it is glitch-free.
    unique case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory subsystem: word RAM plus MMIO window holding
// UART TX, status and a free-running cycle counter. Zero-wait-state.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          BAUD_DIV   = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        uart_tx_o
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_q, status;
  logic [1:0]    off;
  logic          ram_hit, mmio_hit, wr, rd;
  logic          push, full, empty, busy;
  logic [CW-1:0] count;

  assign ram_hit  = data_addr_i < RAM_BYTES;
  assign mmio_hit = data_addr_i[31:4] == MMIO_BASE[31:4];
  assign off      = data_addr_i[3:2];
  assign wr       = data_ce_i && data_we_i;
  assign rd       = data_ce_i && !data_we_i;
  assign push     = wr && mmio_hit && (off == OFF_TXDATA);

  always_ff @(posedge clk) begin
    if (wr && ram_hit)
      ram[data_addr_i[AW+1:2]] <= data_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cycle_q <= '0;
    else if (wr && mmio_hit && (off == OFF_CYCLE))
      cycle_q <= data_wdata_i;
    else
      cycle_q <= cycle_q + 32'd1;
  end

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_wdata_i[7:0]),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .busy      (busy),
    .tx        (uart_tx_o)
  );

  always_comb begin
    status                       = '0;
    status[ST_FULL]              = full;
    status[ST_EMPTY]             = empty;
    status[ST_BUSY]              = busy;
    status[ST_COUNT_LSB +: 4]    = 4'(count);
  end

  always_comb begin
    data_rdata_o = '0;
    if (rd) begin
      unique case (1'b1)
        ram_hit:
          data_rdata_o = ram[data_addr_i[AW+1:2]];
        mmio_hit && (off == OFF_STATUS):
          data_rdata_o = status;
        mmio_hit && (off == OFF_CYCLE):
          data_rdata_o = cycle_q;
        default: ;
      endcase
    end
  end

endmodule
